// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and bus-level constants for the I2C burst master.
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WBYTE, S_WACK, S_RBYTE, S_RACK, S_STOP, S_DONE
  } state_t;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: free-running divider that pulses tick every CLK_DIV clocks while enabled.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == W'(CLK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/i2c_master_burst.sv
// i2c_master_burst: I2C master doing multi-byte burst reads/writes with ACK checking and open-drain SCL/SDA enables.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in
);
  state_t           state, state_n;
  logic [1:0]       ph, ph_n;
  logic [2:0]       bitn, bitn_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [7:0]       sh, sh_n, rxd_n;
  logic             rw_q, rw_n, smp, smp_n, loaded, loaded_n, nack_n, rxv_n;
  logic             scl_n, sda_n, tick, wait_tx;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .en(busy), .tick(tick));

  assign busy     = !(state == S_IDLE || state == S_DONE);
  assign done     = state == S_DONE;
  // SCL stays low in P0 of bit 7 until a write byte has been handed over
  assign wait_tx  = state == S_WBYTE && bitn == 3'd7 && ph == 2'd0 && !loaded;
  assign tx_ready = wait_tx && tx_valid;

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    bitn_n   = bitn;
    cnt_n    = cnt;
    sh_n     = sh;
    rw_n     = rw_q;
    smp_n    = smp;
    loaded_n = loaded;
    nack_n   = nack_err;
    rxd_n    = rx_data;
    rxv_n    = 1'b0;
    if (tx_ready) begin
      sh_n     = tx_data;
      loaded_n = 1'b1;
    end
    if (!busy) begin
      state_n = start ? S_START : S_IDLE;
      if (start) begin
        ph_n   = '0;
        sh_n   = {addr, rw};
        rw_n   = rw;
        cnt_n  = len;
        nack_n = 1'b0;
      end
    end else if (tick && !wait_tx) begin
      ph_n     = ph + 2'd1;
      loaded_n = 1'b0;
      case (state)
        S_START: if (ph == 2'd2) begin
          state_n = S_ADDR;
          ph_n    = '0;
          bitn_n  = 3'd7;
        end
        S_STOP: if (ph == 2'd2) state_n = S_DONE;
        S_ADDR, S_WBYTE, S_RBYTE: begin
          if (ph == 2'd2 && state == S_RBYTE) begin
            sh_n = {sh[6:0], sda_in};
            if (bitn == 3'd0) begin
              rxd_n = {sh[6:0], sda_in};
              rxv_n = 1'b1;
            end
          end
          // bitn wraps back to 7 here, ready for the next byte after the ACK slot
          if (ph == 2'd3) begin
            bitn_n = bitn - 3'd1;
            if (state != S_RBYTE) sh_n = {sh[6:0], 1'b0};
            if (bitn == 3'd0)
              state_n = state == S_ADDR ? S_AACK : state == S_WBYTE ? S_WACK : S_RACK;
          end
        end
        default: begin
          if (ph == 2'd2) smp_n = sda_in;
          if (ph == 2'd3) begin
            if (state != S_RACK && smp == NACK) begin
              nack_n  = 1'b1;
              state_n = S_STOP;
            end else if (state == S_AACK) begin
              state_n = rw_q == RW_READ ? S_RBYTE : S_WBYTE;
            end else if (cnt == '0) begin
              state_n = S_STOP;
            end else begin
              cnt_n   = cnt - 1'b1;
              state_n = state == S_WACK ? S_WBYTE : S_RBYTE;
            end
          end
        end
      endcase
    end
  end

  // Pin enables are registered from the next state so the pads never see decode glitches
  always_comb begin
    scl_n = 1'b0;
    sda_n = 1'b0;
    case (state_n)
      S_START: begin
        scl_n = ph_n == 2'd2;
        sda_n = ph_n != 2'd0;
      end
      S_STOP: begin
        scl_n = ph_n == 2'd0;
        sda_n = ph_n != 2'd2;
      end
      S_ADDR, S_WBYTE: begin
        scl_n = ph_n == 2'd0 || ph_n == 2'd3;
        sda_n = !sh_n[7];
      end
      S_RACK: begin
        scl_n = ph_n == 2'd0 || ph_n == 2'd3;
        sda_n = cnt_n != '0;
      end
      S_AACK, S_WACK, S_RBYTE: scl_n = ph_n == 2'd0 || ph_n == 2'd3;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph       <= '0;
      bitn     <= '0;
      cnt      <= '0;
      sh       <= '0;
      rw_q     <= 1'b0;
      smp      <= 1'b0;
      loaded   <= 1'b0;
      nack_err <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      bitn     <= bitn_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      rw_q     <= rw_n;
      smp      <= smp_n;
      loaded   <= loaded_n;
      nack_err <= nack_n;
      rx_data  <= rxd_n;
      rx_valid <= rxv_n;
      scl_oe   <= scl_n;
      sda_oe   <= sda_n;
    end
  end
endmodule

// File: tb/tb_i2c_master_burst.sv
// tb_i2c_master_burst: scoreboard bench with a behavioural I2C slave on the open-drain bus.
module tb_i2c_master_burst;
  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;

  logic clk = 0, rst_n = 0, start = 0, rw = 0, tx_valid = 0, pull = 0;
  logic [6:0] addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0] tx_data = '0;
  logic tx_ready, rx_valid, busy, done, nack_err, scl_oe, sda_oe, sda_in;
  logic [7:0] rx_data;

  int vectors = 0, miscompares = 0;
  logic [7:0] exp_bus[$], exp_rx[$], tx_q[$], rd_q[$], fixed_q[$];
  logic exp_mack[$], exp_nack[$];
  int exp_ntx[$];
  int took_cnt = 0, took_base = 0, done_cnt = 0, rx_cnt = 0, cyc = 0, stall_cnt = 0, stall_low = 0;
  bit took = 0, stall_arm = 0;
  logic cfg_addr_ack = 1;
  int cfg_nack_idx = -1;

  assign sda_in = ~(sda_oe | pull);
  always #5 clk = ~clk;

  i2c_master_burst #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), .nack_err(nack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Slave: watches bus edges, checks bytes it receives, ACKs/NACKs and serves read data
  int bitc = 0, mode = 0, byteidx = 0, last_rise = 0;
  logic [7:0] shreg = 0, rdbyte = 0;
  logic ackbit = 0, ackd = 0, is_read = 0, p_scl = 1, p_sda = 1;
  always @(negedge clk) begin
    logic c, s;
    cyc++;
    c = ~scl_oe;
    s = sda_in;
    if (!rst_n) begin
      pull = 0;
      mode = 0;
    end else if (c && p_scl && p_sda && !s) begin
      mode = 1; bitc = 0; byteidx = 0; pull = 0;
    end else if (c && p_scl && !p_sda && s) begin
      mode = 0;
    end else if (mode != 0 && c && !p_scl) begin
      if (mode == 1 && bitc == 1) check("bit_period", cyc - last_rise, 4 * CLK_DIV);
      last_rise = cyc;
      if (bitc < 8) shreg = {shreg[6:0], s};
      else ackbit = s;
      bitc++;
    end else if (mode != 0 && !c && p_scl) begin
      if (bitc == 8) begin
        if (mode == 3) pull = 0;
        else begin
          if (exp_bus.size() == 0) extra("bus_byte", shreg);
          else check("bus_byte", shreg, exp_bus.pop_front());
          if (mode == 1) is_read = shreg[0];
          ackd = mode == 1 ? cfg_addr_ack : (byteidx != cfg_nack_idx);
          pull = ackd;
        end
      end else if (bitc == 9) begin
        bitc = 0;
        pull = 0;
        if (mode == 3) begin
          if (exp_mack.size() == 0) extra("master_ack", ackbit);
          else check("master_ack", ackbit, exp_mack.pop_front());
          if (ackbit) mode = 0;
        end else if (!ackd) mode = 0;
        else if (mode == 1) mode = is_read ? 3 : 2;
        else byteidx++;
        if (mode == 3) begin
          rdbyte = rd_q.size() > 0 ? rd_q.pop_front() : 8'hFF;
          pull = !rdbyte[7];
        end
      end else if (mode == 3) pull = !rdbyte[7-bitc];
    end
    p_scl = c;
    p_sda = s;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_rx.size() == 0) extra("rx_data", rx_data);
      else check("rx_data", rx_data, exp_rx.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (exp_nack.size() == 0) extra("done", nack_err);
      else begin
        check("done_nack", nack_err, exp_nack.pop_front());
        check("tx_ready_count", took_cnt - took_base, exp_ntx.pop_front());
      end
      check("busy_at_done", busy, 0);
      took_base = took_cnt;
    end
  end

  // Byte-stream source: offers tx_valid whenever data is queued, optionally stalling before byte 2
  initial forever begin
    @(negedge clk);
    if (took) begin
      void'(tx_q.pop_front());
      took_cnt++;
      if (stall_arm) begin
        stall_cnt = 250;
        stall_arm = 0;
      end
    end
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt < 100 && !scl_oe) stall_low++;
      if (stall_cnt == 0) check("stall_scl_held", stall_low, 0);
    end
    tx_valid = tx_q.size() > 0 && stall_cnt == 0;
    tx_data  = tx_q.size() > 0 ? tx_q[0] : 8'($urandom);
    #1;
    took = tx_valid && tx_ready;
  end

  task automatic run_txn(input logic rw_i, input logic [6:0] a, input logic [LEN_W-1:0] l,
                         input logic aack, input int nidx, input bit stall, input bit poke, input bit rst_mid);
    int n = int'(l) + 1;
    int ntx = 0;
    int d0, r0;
    logic [7:0] b;
    cfg_addr_ack = aack;
    cfg_nack_idx = nidx;
    exp_bus.push_back({a, rw_i});
    for (int i = 0; i < n; i++) begin
      b = fixed_q.size() > 0 ? fixed_q.pop_front() : 8'($urandom);
      if (!rw_i) begin
        tx_q.push_back(b);
        if (aack && (nidx < 0 || i <= nidx)) begin
          exp_bus.push_back(b);
          ntx++;
        end
      end else begin
        rd_q.push_back(b);
        if (aack) begin
          exp_rx.push_back(b);
          exp_mack.push_back(i == n - 1);
        end
      end
    end
    exp_nack.push_back(!aack || (!rw_i && nidx >= 0));
    exp_ntx.push_back(ntx);
    stall_arm = stall;
    d0 = done_cnt;
    r0 = rx_cnt;
    @(negedge clk);
    start = 1; rw = rw_i; addr = a; len = l;
    @(negedge clk);
    start = 0; rw = 1'($urandom); addr = 7'($urandom); len = LEN_W'($urandom);
    check("busy_after_start", busy, 1);
    check("nack_cleared", nack_err, 0);
    if (poke) begin
      repeat (300) @(negedge clk);
      start = 1; rw = ~rw_i; addr = ~a; len = ~l;
      @(negedge clk);
      start = 0;
    end
    if (rst_mid) begin
      for (int t = 0; t < 5000 && rx_cnt == r0; t++) @(negedge clk);
      check("rst_rx_seen", rx_cnt != r0, 1);
      for (int t = 0; t < 100 && !scl_oe; t++) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("rst_scl_oe", scl_oe, 0);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      exp_bus.delete(); exp_rx.delete(); exp_mack.delete(); exp_nack.delete(); exp_ntx.delete();
      rd_q.delete(); tx_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      return;
    end
    for (int t = 0; t < 20000 && done_cnt == d0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("txn_done_count", done_cnt - d0, 1);
    tx_q.delete();
    rd_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_scl_oe", scl_oe, 0);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_nack_err", nack_err, 0);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    fixed_q = '{8'hA5, 8'h3C};
    run_txn(0, 7'h50, 1, 1, -1, 0, 0, 0);
    fixed_q = '{8'h11, 8'h22, 8'h33};
    run_txn(1, 7'h2A, 2, 1, -1, 0, 0, 0);
    run_txn(0, 7'h33, 3, 0, -1, 0, 0, 0);
    check("nack_held", nack_err, 1);
    run_txn(0, 7'h12, 2, 1, -1, 1, 0, 0);
    run_txn(0, 7'h45, 3, 1, 1, 0, 0, 0);
    run_txn(1, 7'h19, 3, 1, -1, 0, 0, 1);
    run_txn(1, 7'h19, 1, 1, -1, 0, 0, 0);
    run_txn(0, 7'h6B, 4, 1, -1, 0, 1, 0);
    run_txn(1, 7'h7F, 15, 1, -1, 0, 0, 0);
    run_txn(0, 7'h01, 15, 1, -1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic r;
      logic [LEN_W-1:0] l;
      r = 1'($urandom);
      l = LEN_W'($urandom_range(0, 7));
      run_txn(r, 7'($urandom), l, ($urandom % 8) != 0,
              (!r && $urandom % 3 == 0) ? int'($urandom_range(0, int'(l))) : -1, 0, 0, 0);
    end
    check("left_bus", exp_bus.size(), 0);
    check("left_rx", exp_rx.size(), 0);
    check("left_mack", exp_mack.size(), 0);
    check("left_done", exp_nack.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
